// File: rtl/mac_operand_splitter_pkg.sv
// mac_operand_splitter_pkg
// Shared constants for the MAC operand splitter front end:
//   - default widths for the config bus, lane slices and wide operands
//   - lane count (always four multiplier lanes)
//   - mode encodings carried in cfg[1:0]
//   - a small helper that tells whether a mode may enter the FIFO
package mac_operand_splitter_pkg;

    localparam int MAC_CONF_WIDTH_DEF = 3;
    localparam int MAC_MIN_WIDTH_DEF  = 8;
    localparam int MAC_LANES          = 4;

    typedef enum logic [1:0] {
        MAC_SINGLE  = 2'b00,
        MAC_DUAL    = 2'b01,
        MAC_QUAD    = 2'b10,
        MAC_ILLEGAL = 2'b11
    } mac_mode_e;

    // Only the illegal encoding is refused; every other mode is stored.
    function automatic logic mac_mode_legal(input logic [1:0] mode);
        return mode != MAC_ILLEGAL;
    endfunction

endpackage

// File: rtl/mac_split_fifo2.sv
// mac_split_fifo2
// Generic two-entry valid/ready FIFO with 1-bit wrap-around pointers.
// Ports:
//   clk, rst       clock and synchronous active-high reset (clears entries)
//   en             global enable; low suppresses both push and pop
//   in_valid/in_ready/in_data     write side; in_ready depends only on count
//   out_valid/out_ready/out_data  read side; out_data is the head entry
module mac_split_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = en & in_valid & in_ready;
    assign pop       = en & out_valid & out_ready;

    // Next-state: write at wr_ptr, advance pointers, net count change.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Reset clears the storage too, so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mac_operand_splitter.sv
// mac_operand_splitter
// Splits one wide A/B operand pair into four per-lane multiplier operand
// pairs according to cfg[1:0] (single/dual/quad), buffers up to two split
// beats, and tags each beat with the cfg it was accepted under.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en                     global enable for both handshakes
//   cfg                    mode; 11 is illegal (beat dropped, err set)
//   in_valid/in_ready      upstream handshake, a_in/b_in wide operands
//   out_valid/out_ready    downstream handshake for the head beat
//   out_cfg                cfg captured with the head beat
//   lane_a0..3, lane_b0..3 per-lane multiplicand / multiplier
//   err                    sticky illegal-cfg flag
// Optional macro MAC_SPLIT_STATS_EN adds stat_single/stat_dual/stat_quad,
// 16-bit wrapping counts of popped beats per mode.
module mac_operand_splitter
    import mac_operand_splitter_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = MAC_CONF_WIDTH_DEF,
    parameter int MAC_MIN_WIDTH  = MAC_MIN_WIDTH_DEF,
    parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_ACC_WIDTH-1:0]  a_in,
    input  logic [MAC_ACC_WIDTH-1:0]  b_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_CONF_WIDTH-1:0] out_cfg,
    output logic [MAC_ACC_WIDTH-1:0]  lane_a0,
    output logic [MAC_ACC_WIDTH-1:0]  lane_a1,
    output logic [MAC_ACC_WIDTH-1:0]  lane_a2,
    output logic [MAC_ACC_WIDTH-1:0]  lane_a3,
    output logic [MAC_MIN_WIDTH-1:0]  lane_b0,
    output logic [MAC_MIN_WIDTH-1:0]  lane_b1,
    output logic [MAC_MIN_WIDTH-1:0]  lane_b2,
    output logic [MAC_MIN_WIDTH-1:0]  lane_b3,
`ifdef MAC_SPLIT_STATS_EN
    output logic                      err,
    output logic [15:0]               stat_single,
    output logic [15:0]               stat_dual,
    output logic [15:0]               stat_quad
`else
    output logic                      err
`endif
);

    localparam int M      = MAC_MIN_WIDTH;
    localparam int A_BASE = MAC_LANES * M;
    localparam int DATA_W = MAC_CONF_WIDTH + MAC_LANES * (MAC_ACC_WIDTH + M);

    logic [MAC_ACC_WIDTH-1:0] split_a [MAC_LANES];
    logic [M-1:0]             split_b [MAC_LANES];
    logic [DATA_W-1:0]        push_data, head_data;
    logic                     cfg_legal;
    logic                     err_q, err_d;

    assign cfg_legal = mac_mode_legal(cfg[1:0]);

    // Operand split; illegal mode falls into the quad arm but is never stored.
    always_comb begin
        for (int i = 0; i < MAC_LANES; i++) begin
            split_b[i] = b_in[M*i +: M];
            split_a[i] = '0;
            case (mac_mode_e'(cfg[1:0]))
                MAC_SINGLE: split_a[i][M-1:0]   = a_in[M*i +: M];
                MAC_DUAL:   split_a[i][2*M-1:0] = a_in[2*M*(i/2) +: 2*M];
                default:    split_a[i]          = a_in;
            endcase
        end
    end

    assign push_data = {cfg,
                        split_a[3], split_a[2], split_a[1], split_a[0],
                        split_b[3], split_b[2], split_b[1], split_b[0]};

    // Illegal beats still see in_ready (they are consumed) but never write.
    mac_split_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid & cfg_legal),
        .in_ready  (in_ready),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_data)
    );

    assign out_cfg = head_data[DATA_W-1 -: MAC_CONF_WIDTH];
    assign lane_a3 = head_data[A_BASE + 3*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    assign lane_a2 = head_data[A_BASE + 2*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    assign lane_a1 = head_data[A_BASE + 1*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
    assign lane_a0 = head_data[A_BASE +: MAC_ACC_WIDTH];
    assign lane_b3 = head_data[3*M +: M];
    assign lane_b2 = head_data[2*M +: M];
    assign lane_b1 = head_data[1*M +: M];
    assign lane_b0 = head_data[0 +: M];

    // Sticky error: any accepted handshake carrying the illegal mode.
    always_comb begin
        err_d = err_q | (en & in_valid & in_ready & ~cfg_legal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifdef MAC_SPLIT_STATS_EN
    logic        pop_fire;
    logic [15:0] stat_single_q, stat_single_d;
    logic [15:0] stat_dual_q, stat_dual_d;
    logic [15:0] stat_quad_q, stat_quad_d;

    assign pop_fire = en & out_valid & out_ready;

    // Count pops by the mode tag of the beat leaving; counters wrap.
    always_comb begin
        stat_single_d = stat_single_q;
        stat_dual_d   = stat_dual_q;
        stat_quad_d   = stat_quad_q;
        if (pop_fire) begin
            case (mac_mode_e'(out_cfg[1:0]))
                MAC_SINGLE: stat_single_d = stat_single_q + 16'd1;
                MAC_DUAL:   stat_dual_d   = stat_dual_q + 16'd1;
                MAC_QUAD:   stat_quad_d   = stat_quad_q + 16'd1;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_single_q <= 16'd0;
            stat_dual_q   <= 16'd0;
            stat_quad_q   <= 16'd0;
        end else begin
            stat_single_q <= stat_single_d;
            stat_dual_q   <= stat_dual_d;
            stat_quad_q   <= stat_quad_d;
        end
    end

    assign stat_single = stat_single_q;
    assign stat_dual   = stat_dual_q;
    assign stat_quad   = stat_quad_q;
`endif

endmodule

// File: tb/tb_mac_operand_splitter.sv
// tb_mac_operand_splitter
// Self-checking bench: directed literal scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the two-deep buffer.
module tb_mac_operand_splitter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  cfg;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_cfg;
    logic [31:0] lane_a0, lane_a1, lane_a2, lane_a3;
    logic [7:0]  lane_b0, lane_b1, lane_b2, lane_b3;
    logic        err;
`ifdef MAC_SPLIT_STATS_EN
    logic [15:0] stat_single, stat_dual, stat_quad;
`endif

    mac_operand_splitter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cfg    (out_cfg),
        .lane_a0    (lane_a0),
        .lane_a1    (lane_a1),
        .lane_a2    (lane_a2),
        .lane_a3    (lane_a3),
        .lane_b0    (lane_b0),
        .lane_b1    (lane_b1),
        .lane_b2    (lane_b2),
        .lane_b3    (lane_b3),
`ifdef MAC_SPLIT_STATS_EN
        .err        (err),
        .stat_single(stat_single),
        .stat_dual  (stat_dual),
        .stat_quad  (stat_quad)
`else
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       cfg;
        logic [3:0][31:0] a;
        logic [3:0][7:0]  b;
    } beat_t;

    beat_t       expQ[$];
    logic        modelErr;
    logic [15:0] modelSingle, modelDual, modelQuad;
    int          numChecks;
    int          numErrors;
    logic        checkEn;

    // What each lane must receive, worked out with shifts and masks.
    function automatic beat_t modelSplit(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
        beat_t r;
        r.cfg = c;
        for (int i = 0; i < 4; i++) begin
            r.b[i] = 8'((b >> (8 * i)) & 32'hFF);
            case (c[1:0])
                2'b00:   r.a[i] = (a >> (8 * i)) & 32'hFF;
                2'b01:   r.a[i] = (i < 2) ? (a & 32'hFFFF) : (a >> 16);
                default: r.a[i] = a;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [2:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic ordy);
        rst       = r;
        en        = e;
        in_valid  = v;
        cfg       = c;
        a_in      = a;
        b_in      = b;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of at most two pre-split beats.
    always @(posedge clk) begin
        logic doPop, doPush;
        if (rst) begin
            expQ.delete();
            modelErr    = 1'b0;
            modelSingle = '0;
            modelDual   = '0;
            modelQuad   = '0;
        end else if (en) begin
            doPop  = out_ready && (expQ.size() != 0);
            doPush = in_valid && (expQ.size() < 2);
            if (doPop) begin
                case (expQ[0].cfg[1:0])
                    2'b00:   modelSingle = modelSingle + 16'd1;
                    2'b01:   modelDual   = modelDual + 16'd1;
                    default: modelQuad   = modelQuad + 16'd1;
                endcase
                void'(expQ.pop_front());
            end
            if (doPush) begin
                if (cfg[1:0] == 2'b11) modelErr = 1'b1;
                else expQ.push_back(modelSplit(cfg, a_in, b_in));
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
            checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
            checkOutput("err", 32'(err), 32'(modelErr));
            if (expQ.size() != 0) begin
                checkOutput("out_cfg", 32'(out_cfg), 32'(expQ[0].cfg));
                checkOutput("lane_a0", lane_a0, expQ[0].a[0]);
                checkOutput("lane_a1", lane_a1, expQ[0].a[1]);
                checkOutput("lane_a2", lane_a2, expQ[0].a[2]);
                checkOutput("lane_a3", lane_a3, expQ[0].a[3]);
                checkOutput("lane_b0", 32'(lane_b0), 32'(expQ[0].b[0]));
                checkOutput("lane_b1", 32'(lane_b1), 32'(expQ[0].b[1]));
                checkOutput("lane_b2", 32'(lane_b2), 32'(expQ[0].b[2]));
                checkOutput("lane_b3", 32'(lane_b3), 32'(expQ[0].b[3]));
            end
`ifdef MAC_SPLIT_STATS_EN
            checkOutput("stat_single", 32'(stat_single), 32'(modelSingle));
            checkOutput("stat_dual", 32'(stat_dual), 32'(modelDual));
            checkOutput("stat_quad", 32'(stat_quad), 32'(modelQuad));
`endif
        end
    end

    initial begin
        numChecks = 0;
        numErrors = 0;
        checkEn   = 1'b0;
        modelErr  = 1'b0;
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; cfg = '0;
        a_in = '0; b_in = '0; out_ready = 1'b0;

        // Reset then idle: empty buffer, zeroed lanes.
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0);
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_out_cfg", 32'(out_cfg), 32'd0);
        checkOutput("rst_lane_a0", lane_a0, 32'd0);
        checkOutput("rst_lane_a3", lane_a3, 32'd0);
        checkOutput("rst_lane_b0", 32'(lane_b0), 32'd0);
        checkEn = 1'b1;
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 0);

        // Single mode, one-cycle latency.
        applyStimulus(0, 1, 1, 3'b000, 32'h44332211, 32'h88776655, 1);
        checkOutput("single_a0", lane_a0, 32'h11);
        checkOutput("single_a1", lane_a1, 32'h22);
        checkOutput("single_a2", lane_a2, 32'h33);
        checkOutput("single_a3", lane_a3, 32'h44);
        checkOutput("single_b0", 32'(lane_b0), 32'h55);
        checkOutput("single_b1", 32'(lane_b1), 32'h66);
        checkOutput("single_b2", 32'(lane_b2), 32'h77);
        checkOutput("single_b3", 32'(lane_b3), 32'h88);
        checkOutput("single_cfg", 32'(out_cfg), 32'd0);

        // Dual then quad back-to-back at full throughput.
        applyStimulus(0, 1, 1, 3'b001, 32'hBEEFCAFE, 32'h0, 1);
        checkOutput("dual_a0", lane_a0, 32'h0000CAFE);
        checkOutput("dual_a1", lane_a1, 32'h0000CAFE);
        checkOutput("dual_a2", lane_a2, 32'h0000BEEF);
        checkOutput("dual_a3", lane_a3, 32'h0000BEEF);
        checkOutput("dual_cfg", 32'(out_cfg), 32'd1);
        applyStimulus(0, 1, 1, 3'b010, 32'hBEEFCAFE, 32'h0, 1);
        checkOutput("quad_a0", lane_a0, 32'hBEEFCAFE);
        checkOutput("quad_a2", lane_a2, 32'hBEEFCAFE);
        checkOutput("quad_cfg", 32'(out_cfg), 32'd2);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: third beat waits until a slot frees up.
        applyStimulus(0, 1, 1, 3'd0, 32'hA1, 0, 0);
        applyStimulus(0, 1, 1, 3'd0, 32'hA2, 0, 0);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_head", lane_a0, 32'hA1);
        applyStimulus(0, 1, 1, 3'd0, 32'hA3, 0, 0);
        checkOutput("full_hold", lane_a0, 32'hA1);
        applyStimulus(0, 1, 1, 3'd0, 32'hA3, 0, 1);
        checkOutput("bp_second", lane_a0, 32'hA2);
        applyStimulus(0, 1, 1, 3'd0, 32'hA3, 0, 1);
        checkOutput("bp_third", lane_a0, 32'hA3);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);

        // Illegal cfg with one beat buffered.
        applyStimulus(0, 1, 1, 3'd0, 32'h55, 0, 0);
        applyStimulus(0, 1, 1, 3'b011, 32'hDEAD, 0, 0);
        checkOutput("ill_err", 32'(err), 32'd1);
        checkOutput("ill_in_ready", 32'(in_ready), 32'd1);
        checkOutput("ill_head", lane_a0, 32'h55);
        applyStimulus(0, 1, 1, 3'd0, 32'h66, 0, 1);
        checkOutput("ill_next", lane_a0, 32'h66);
        checkOutput("ill_sticky", 32'(err), 32'd1);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);

        // Enable low freezes both handshakes.
        applyStimulus(0, 1, 1, 3'd0, 32'h77, 0, 0);
        applyStimulus(0, 0, 1, 3'd0, 32'h88, 0, 1);
        applyStimulus(0, 0, 1, 3'd0, 32'h88, 0, 1);
        checkOutput("en0_head", lane_a0, 32'h77);
        checkOutput("en0_valid", 32'(out_valid), 32'd1);
        applyStimulus(0, 1, 1, 3'd0, 32'h88, 0, 1);
        checkOutput("en1_head", lane_a0, 32'h88);
        checkOutput("en1_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);

        // Reset clears the sticky flag.
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0);
        checkOutput("rst_clr_err", 32'(err), 32'd0);
        checkOutput("rst_clr_valid", 32'(out_valid), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) c[1:0] = 2'b11;
            else if (c[1:0] == 2'b11) c[1:0] = 2'($urandom_range(0, 2));
            applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 1)), c, $urandom, $urandom,
                          ($urandom_range(0, 3) != 0));
        end
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);
        applyStimulus(0, 1, 0, 3'd0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/mac_operand_splitter.md
Name: mac_operand_splitter

Overview:
- Front-end counterpart of the MAC partial-product combiner.
- Takes one wide A/B operand pair plus a width config (single/dual/quad) and splits it into four per-lane multiplier operand pairs, so the combiner can later reassemble the lane partials.
- Buffers up to two beats in a 2-entry FIFO with valid/ready on both sides.
- Tags each beat with the config it was accepted under, so cfg changes never corrupt in-flight beats.

Parameters:
- MAC_CONF_WIDTH, 3, config bus width; bits [1:0] select mode.
- MAC_MIN_WIDTH, 8, lane B-operand width and slice granularity.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, wide operand width and lane A-operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes all state and suppresses both handshakes.
- cfg  in  MAC_CONF_WIDTH  mode: [1:0]=00 single, 01 dual, 10 quad, 11 illegal.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  splitter can accept a beat.
- a_in  in  MAC_ACC_WIDTH  wide multiplicand.
- b_in  in  MAC_ACC_WIDTH  wide multiplier.
- out_valid  out  1  head beat valid.
- out_ready  in  1  lanes accept head beat.
- out_cfg  out  MAC_CONF_WIDTH  cfg captured with head beat.
- lane_a0..lane_a3  out  MAC_ACC_WIDTH each  lane multiplicands.
- lane_b0..lane_b3  out  MAC_MIN_WIDTH each  lane multipliers.
- err  out  1  sticky illegal-cfg flag.

Behaviour:
- Reset (rst=1 at posedge):
  - count=0, err=0.
  - Both FIFO entries cleared, so all lane outputs and out_cfg read 0.
  - out_valid=0. in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all buffered beats.
- Handshake rules:
  - in_ready = (count<2). Combinational from the count register, independent of out_ready.
  - push = en & in_valid & in_ready. pop = en & out_valid & out_ready.
  - out_valid = (count!=0). Held with stable data until popped, regardless of en.
- Latency:
  - Beat accepted at edge N is visible on outputs after edge N when the FIFO was empty: 1 cycle.
  - Full throughput of 1 beat/cycle when out_ready stays high.
- Simultaneous push and pop:
  - count=1: count stays 1; new beat becomes head after the pop.
  - count=2: push impossible (in_ready=0); pop alone takes count to 1.
  - count=0: pop impossible.
- Split, performed at push and stored pre-split; i=0..3, M=MAC_MIN_WIDTH:
  - All modes: lane_bi = b_in[M*i +: M].
  - single: lane_ai = zero-extended a_in[M*i +: M].
  - dual: lanes 0,1 get zero-extended a_in[2M-1:0]; lanes 2,3 get zero-extended a_in[4M-1:2M].
  - quad: all lanes get a_in unchanged.
- Illegal cfg (11) on a push:
  - Beat is consumed (in_ready honoured) but not written; count unchanged.
  - err sets and stays set until rst.
- cfg may change every cycle. Each beat carries its own out_cfg, so the combiner selects its mode from out_cfg, not live cfg.
- Storage: FIFO is two entries with wrap-around read/write pointers (1 bit each).

Optional Feature:
- Macro: MAC_SPLIT_STATS_EN.
- Defined:
  - Adds outputs stat_single, stat_dual, stat_quad, 16 bits each.
  - Each counts pops in that mode; wraps 0xFFFF→0; cleared by rst.
  - Illegal beats are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/header, mac_const.vh:
  - Mode encodings MAC_SINGLE=2'b00, MAC_DUAL=2'b01, MAC_QUAD=2'b10, MAC_ILLEGAL=2'b11.
  - Lane count 4.
- One sub-module, mac_split_fifo2: generic 2-entry valid/ready FIFO holding {cfg, 4×lane_a, 4×lane_b}.
- mac_operand_splitter holds the split logic, err and stats.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, err=0, all lanes 0.
- Single mode, a_in=0x44332211, b_in=0x88776655, out_ready=1 → next cycle lane_a0..3=0x11,0x22,0x33,0x44 (zero-extended), lane_b0..3=0x55,0x66,0x77,0x88, out_cfg=00.
- Dual, a_in=0xBEEFCAFE → lane_a0=lane_a1=0x0000CAFE, lane_a2=lane_a3=0x0000BEEF. Then quad with same a_in → all lanes 0xBEEFCAFE. out_cfg follows each beat.
- Backpressure, out_ready=0, push 3 beats → first two accepted, in_ready=0 on third. Release out_ready → beats pop in order; third accepted when count<2.
- cfg=11 push while count=1 → count stays 1, err=1 and sticky. Next legal beat still flows; rst clears err.
- en=0 with in_valid=out_ready=1 and count=1 → no push, no pop, outputs stable. en=1 → push and pop in the same cycle, count stays 1.
